// File: rtl/score_keeper.sv
// Game-score engine: tick/bonus scoring with saturation, pause/resume, session
// high score and a sequential binary-to-BCD copy of the score for the display.
module score_keeper #(
  parameter int SCORE_W  = 10,
  parameter int TICK_DIV = 20000000,
  parameter int BONUS_W  = 4,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ending,
  input  logic                  pause,
  input  logic                  bonus_valid,
  input  logic [BONUS_W-1:0]    bonus_pts,
  output logic [SCORE_W-1:0]    score_out,
  output logic [SCORE_W-1:0]    high_score,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  bcd_valid,
  output logic                  running,
  output logic                  new_high,
  output logic [1:0]            dbg_state
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = SCORE_W + BONUS_W + 1;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [SCORE_W-1:0] r_high;
  logic               r_new_high, r_running;
  logic [SCORE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_work, r_bcd, w_adj, w_work_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bcd_valid;
  logic               w_tick, w_enter_over, w_score_chg;
  logic [SUM_W-1:0]   w_sum;

  assign w_tick       = (r_state == RUN) && (r_div == DIV_MAX);
  assign w_sum        = SUM_W'(r_score) + SUM_W'(w_tick) +
                        (bonus_valid ? SUM_W'(bonus_pts) : '0);
  assign w_enter_over = !start && ending && ((r_state == RUN) || (r_state == PAUSE));
  assign w_score_chg  = (w_score_nxt != r_score);

  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = RUN;
    else if (w_enter_over)
      w_state_nxt = OVER;
    else if ((r_state == RUN) && pause)
      w_state_nxt = PAUSE;
    else if ((r_state == PAUSE) && !pause)
      w_state_nxt = RUN;

    w_score_nxt = r_score;
    if (start)
      w_score_nxt = '0;
    else if (r_state == RUN)
      w_score_nxt = (w_sum > {{(BONUS_W+1){1'b0}}, SCORE_MAX}) ? SCORE_MAX : w_sum[SCORE_W-1:0];

    w_div_nxt = '0;
    if (!start) begin
      case (r_state)
        RUN:     w_div_nxt = w_tick ? '0 : r_div + 1'b1;
        PAUSE:   w_div_nxt = r_div;
        default: w_div_nxt = '0;
      endcase
    end
  end

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next binary MSB.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++)
      if (r_work[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
    w_work_nxt = {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_score     <= '0;
      r_high      <= '0;
      r_new_high  <= 1'b0;
      r_running   <= 1'b0;
      r_bin       <= '0;
      r_work      <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_bcd_valid <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_score   <= w_score_nxt;
      r_running <= (w_state_nxt == RUN);

      if (start)
        r_new_high <= 1'b0;
      else if (w_enter_over && (w_score_nxt > r_high)) begin
        r_high     <= w_score_nxt;
        r_new_high <= 1'b1;
      end

      // bcd_valid=1 means score_bcd matches score_out; any score change restarts conversion.
      if (w_score_chg) begin
        r_bin       <= w_score_nxt;
        r_work      <= '0;
        r_cnt       <= CNT_W'(SCORE_W);
        r_bcd_valid <= 1'b0;
      end else if (r_cnt != '0) begin
        r_bin  <= r_bin << 1;
        r_work <= w_work_nxt;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_bcd       <= w_work_nxt;
          r_bcd_valid <= 1'b1;
        end
      end
    end
  end

  assign score_out  = r_score;
  assign high_score = r_high;
  assign score_bcd  = r_bcd;
  assign bcd_valid  = r_bcd_valid;
  assign running    = r_running;
  assign new_high   = r_new_high;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (TICK_DIV=4): main flow checks scores and flags,
// a monitor pops expected scores whenever a BCD conversion completes.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst, start, ending, pause, bonus_valid;
  logic [3:0]  bonus_pts;
  logic [9:0]  score_out, high_score;
  logic [15:0] score_bcd;
  logic        bcd_valid, running, new_high;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [9:0] exp_q[$];

  score_keeper #(.SCORE_W(10), .TICK_DIV(4), .BONUS_W(4), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ending(ending), .pause(pause),
    .bonus_valid(bonus_valid), .bonus_pts(bonus_pts),
    .score_out(score_out), .high_score(high_score), .score_bcd(score_bcd),
    .bcd_valid(bcd_valid), .running(running), .new_high(new_high),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bcd(input int target, input int budget);
    for (int i = 0; i < budget && n_pop < target; i++) step(1);
    n_tests++;
    if (n_pop < target) begin
      n_fail++;
      $display("FAIL bcd_timeout: pops %0d expected %0d", n_pop, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"},     score_out,  0);
    check({tag, "_high"},      high_score, 0);
    check({tag, "_bcd"},       score_bcd,  0);
    check({tag, "_bcd_valid"}, bcd_valid,  1);
    check({tag, "_running"},   running,    0);
    check({tag, "_new_high"},  new_high,   0);
    check({tag, "_state"},     dbg_state,  0);
  endtask

  // scoreboard monitor: a rising bcd_valid is the DUT presenting a result
  initial begin
    logic       prev;
    logic [9:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && bcd_valid && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bcd_unexpected: score %0d bcd %0h with nothing expected", score_out, score_bcd);
        end else begin
          e = exp_q.pop_front();
          check("bcd_score", score_out, e);
          check("bcd_digits", score_bcd, to_bcd(e));
        end
        n_pop++;
      end
      prev = bcd_valid;
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; ending = 1'b0; pause = 1'b0;
    bonus_valid = 1'b0; bonus_pts = '0;
    step(2);
    check_reset_vals("reset");
    rst = 1'b1;
    step(1);

    // 1: round with ticks every 4 cycles
    start = 1'b1; step(1); start = 1'b0;
    check("run_after_start", running, 1);
    check("score_after_start", score_out, 0);
    step(3);  check("score_before_tick", score_out, 0);
    step(1);  check("first_tick", score_out, 1);
    step(36); check("score_40", score_out, 10);
    check("running_40", running, 1);

    // 2: pause 6 cycles mid-period
    step(2);
    pause = 1'b1; step(6);
    check("paused_score", score_out, 10);
    check("paused_running", running, 0);
    check("paused_state", dbg_state, 2);
    pause = 1'b0; step(1);
    check("resume_score", score_out, 10);
    check("resume_running", running, 1);
    step(1);
    check("resume_tick", score_out, 11);
    check("abort_at_final", bcd_valid, 0);

    // 4: high score across two rounds
    step(56); check("score_25", score_out, 25);
    ending = 1'b1; exp_q.push_back(10'd25); step(1); ending = 1'b0;
    check("over_score", score_out, 25);
    check("over_high", high_score, 25);
    check("over_new_high", new_high, 1);
    check("over_state", dbg_state, 3);
    wait_bcd(1, 30);
    start = 1'b1; step(1); start = 1'b0;
    check("start_clears_new_high", new_high, 0);
    check("start_keeps_high", high_score, 25);
    step(100); check("r2_score_25", score_out, 25);
    ending = 1'b1; step(1); ending = 1'b0;
    check("equal_high", high_score, 25);
    check("equal_no_new_high", new_high, 0);
    exp_q.push_back(10'd25);
    wait_bcd(2, 30);

    // 5: BCD conversions 99 -> 100 and an aborted conversion
    start = 1'b1; step(1); start = 1'b0;
    bonus_valid = 1'b1; bonus_pts = 4'd15; step(6);
    check("bonus_91", score_out, 91);
    bonus_pts = 4'd7; step(1);
    check("bonus_98", score_out, 98);
    bonus_valid = 1'b0; step(1);
    check("tick_99", score_out, 99);
    pause = 1'b1; exp_q.push_back(10'd99);
    wait_bcd(3, 20);
    pause = 1'b0; step(1);
    bonus_valid = 1'b1; bonus_pts = 4'd1; step(1);
    bonus_valid = 1'b0; pause = 1'b1;
    check("score_100", score_out, 100);
    check("bcd_low_at_change", bcd_valid, 0);
    exp_q.push_back(10'd100);
    step(9);
    check("bcd_low_10th", bcd_valid, 0);
    check("bcd_holds_prev", score_bcd, 16'h0099);
    step(1);
    check("bcd_valid_100", bcd_valid, 1);
    check("bcd_100", score_bcd, 16'h0100);
    wait_bcd(4, 5);
    pause = 1'b0; step(1);
    step(1); check("score_101", score_out, 101);
    step(1);
    bonus_valid = 1'b1; bonus_pts = 4'd4; step(1);
    bonus_valid = 1'b0; pause = 1'b1;
    check("score_105", score_out, 105);
    exp_q.push_back(10'd105);
    step(9);
    check("restart_still_low", bcd_valid, 0);
    check("restart_holds_100", score_bcd, 16'h0100);
    step(1);
    check("bcd_105", score_bcd, 16'h0105);
    wait_bcd(5, 5);

    // 3: saturation with bonus coincident with a tick
    pause = 1'b0; step(1);
    bonus_valid = 1'b1; bonus_pts = 4'd15; step(60);
    check("score_1020", score_out, 1020);
    bonus_pts = 4'd7; step(1);
    check("sat_1023", score_out, 1023);
    bonus_valid = 1'b0; exp_q.push_back(10'd1023);
    step(4);
    check("sat_after_tick", score_out, 1023);
    bonus_valid = 1'b1; bonus_pts = 4'd15; step(2);
    bonus_valid = 1'b0;
    check("sat_after_bonus", score_out, 1023);
    wait_bcd(6, 20);

    // 6: start beats ending; async reset mid-conversion
    start = 1'b1; ending = 1'b1; step(1); start = 1'b0; ending = 1'b0;
    check("start_beats_end_state", dbg_state, 1);
    check("start_beats_end_score", score_out, 0);
    check("start_beats_end_high", high_score, 25);
    check("clear_launches_conv", bcd_valid, 0);
    step(2);
    #2 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    step(2);
    rst = 1'b1;
    step(2);
    check("idle_after_rst", dbg_state, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
